toggle_seq_ctrl: RTL and testbench
==================================

// Module: toggle_seq_ctrl
// PURPOSE
//  Sequencer/arbiter that shares one Start/Stop/Clear toggle detector (input A, pulses K1/K2) among NREQ requesters.
//  Round-robin grant, then drives A through the full IDLE->Start->Stop->Clear->IDLE pattern.
//  Checks that K2 and K1 come back in order, within a timeout. On protocol error, resets the detector.
//  Sits between requester logic and the detector; owns the detector's A input and its reset.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  HOLD  3   cycles A is held in each drive phase S1/S2 (>=1)
//  TMO   15  max cycles waiting for K2 (in S3) or K1 (in S4) (>=1)
//  IDW   2   width of err_id, = clog2(NREQ)
// PORTS
//  clk       in   1     clock, rising edge
//  rst       in   1     reset, synchronous, active-low
//  req       in   NREQ  level request per requester; held until done/err
//  grant     out  NREQ  one-hot, high for the whole sequence
//  done      out  NREQ  1-cycle pulse to the granted requester on success
//  err       out  1     1-cycle pulse on protocol error or timeout
//  err_id    out  IDW   index of the requester granted at the error; valid with err
//  busy      out  1     high from grant up to and including the done/err cycle
//  A_out     out  1     drives the detector's A input
//  det_rst_n out  1     drives the detector's rst (sync, active-low)
//  K1_in     in   1     detector K1 (combinational, high in Clear && !A)
//  K2_in     in   1     detector K2 (combinational, high in Stop && A)
// BEHAVIOUR
//  Output registration
//  - All outputs registered.
//  - Reset values: grant=0, done=0, err=0, err_id=0, busy=0, A_out=0, det_rst_n=0.
//  - Reset also sets the RR pointer to 0 (req[0] has highest priority first).
//  - After rst is released, det_rst_n goes to 1 on the next edge.
//  State machine
//  - States: IDLE, S1, S2, S3, S4, DONE, ERR.
//  IDLE
//  - If req!=0, pick the first set bit at or after the RR pointer, circularly.
//  - Next cycle: state S1, grant[i]=1, busy=1, A_out=1.
//  - req-to-grant latency is 1 cycle.
//  S1, S2
//  - S1: A_out=1 for HOLD cycles, then S2.
//  - S2: A_out=0 for HOLD cycles, then S3.
//  - K1_in or K2_in sampled high in S1/S2 -> ERR.
//  S3
//  - A_out=1.
//  - K2_in sampled high -> S4.
//  - K1_in high -> ERR.
//  - TMO cycles in S3 without K2 -> ERR.
//  S4
//  - A_out=0.
//  - K1_in sampled high -> DONE.
//  - K2_in high -> ERR.
//  - TMO cycles in S4 without K1 -> ERR.
//  DONE (1 cycle)
//  - done[i]=1, grant=0, busy=1, A_out=0.
//  - RR pointer <= i+1 mod NREQ.
//  - Next state IDLE; at least one IDLE cycle between grants.
//  ERR (1 cycle)
//  - err=1, err_id=i, det_rst_n=0, grant=0, busy=1, A_out=0.
//  - RR pointer <= i+1 mod NREQ.
//  - Next state IDLE.
//  Timing with a correct detector (grant at cycle T)
//  - S3 starts at T+2*HOLD; K2 is seen in that same cycle.
//  - S4 starts at T+2*HOLD+1; K1 is seen in that same cycle.
//  - done pulses at T+2*HOLD+2.
//  Boundary and corner cases
//  - req deasserted mid-sequence: no abort; sequence completes and done/err still pulses.
//  - Same requester's req still high after done: re-eligible, but behind others per the RR pointer.
//  - Changes to req during a sequence have no effect until IDLE.
//  - rst low mid-sequence: all outputs and state return to reset values at the next edge, regardless of state.
//  - Phase and timeout counters: clog2(max(HOLD,TMO)+1) bits, cleared on every state entry, never wrap.
// TESTING
//  1. HOLD=3, req=4'b0100 from idle -> grant=4'b0100 at T.
//     A_out: 1,1,1,0,0,0,1,0 over T..T+7; done[2] pulse at T+8; busy T..T+8.
//  2. req=4'b1111 held after reset -> grant order 0,1,2,3,0.
//     Each done followed by >=1 IDLE cycle.
//  3. K2_in tied 0, req[1] -> err=1, err_id=1 at T+2*HOLD+TMO (T+21).
//     det_rst_n=0 that cycle; no done.
//  4. K1_in forced high in cycle T+1 (S1) -> err at T+2, det_rst_n=0.
//     Next arbitration starts at req index 2.
//  5. rst low during S2 -> next edge: grant=0, A_out=0, det_rst_n=0.
//     After release with req[3] held: grant[3] asserts 2 cycles after release.
//  6. req[0] dropped at T+2 -> sequence continues; done[0] pulses at T+8.

Source files
------------

// File: rtl/toggle_seq_ctrl.sv
// Round-robin sequencer sharing one Start/Stop/Clear toggle detector among NREQ requesters.
// Drives A through a full toggle cycle per grant and checks that K2 then K1 return in time.
module toggle_seq_ctrl #(
  parameter int NREQ = 4,
  parameter int HOLD = 3,
  parameter int TMO  = 15,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic [IDW-1:0]  err_id,
  output logic            busy,
  output logic            A_out,
  output logic            det_rst_n,
  input  logic            K1_in,
  input  logic            K2_in
);

  localparam int MAXC = (HOLD > TMO) ? HOLD : TMO;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW1  = IDW + 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_S1, ST_S2, ST_S3, ST_S4, ST_DONE, ST_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  id_q, id_d, ptr_q, ptr_d;
  logic [NREQ-1:0] grant_q, grant_d, done_q, done_d;
  logic            err_q, err_d, busy_q, busy_d, a_q, a_d, det_rst_n_q, det_rst_n_d;
  logic [IDW-1:0]  err_id_q, err_id_d;

  logic [NREQ-1:0] rot, first_oh;
  logic [IDW-1:0]  off, pick, id_inc;
  logic [IDW:0]    pick_sum;
  logic            pick_vld, hold_last, tmo_last;

  // Rotate requests so the pointer lands on bit 0, isolate the lowest set bit, encode it.
  assign rot      = NREQ'({req, req} >> ptr_q);
  assign first_oh = rot & (~rot + NREQ'(1));
  assign pick_vld = |req;

  for (genvar gi = 0; gi < IDW; gi++) begin : g_off
    logic [NREQ-1:0] sel;
    for (genvar gj = 0; gj < NREQ; gj++) begin : g_sel
      assign sel[gj] = first_oh[gj] && (((gj >> gi) & 1) != 0);
    end
    assign off[gi] = |sel;
  end

  assign pick_sum  = {1'b0, ptr_q} + {1'b0, off};
  assign pick      = (pick_sum >= IW1'(NREQ)) ? IDW'(pick_sum - IW1'(NREQ)) : pick_sum[IDW-1:0];
  assign id_inc    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
  assign hold_last = (cnt_q == CW'(HOLD - 1));
  assign tmo_last  = (cnt_q == CW'(TMO - 1));

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (state_q)
      // No grant while the detector is still coming out of reset.
      ST_IDLE: if (pick_vld && det_rst_n_q) begin
        state_d = ST_S1;
        id_d    = pick;
      end
      ST_S1: begin
        if (K1_in || K2_in)  state_d = ST_ERR;
        else if (hold_last)  state_d = ST_S2;
      end
      ST_S2: begin
        if (K1_in || K2_in)  state_d = ST_ERR;
        else if (hold_last)  state_d = ST_S3;
      end
      ST_S3: begin
        if (K1_in)           state_d = ST_ERR;
        else if (K2_in)      state_d = ST_S4;
        else if (tmo_last)   state_d = ST_ERR;
      end
      ST_S4: begin
        if (K2_in)           state_d = ST_ERR;
        else if (K1_in)      state_d = ST_DONE;
        else if (tmo_last)   state_d = ST_ERR;
      end
      ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
        ptr_d   = id_inc;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)   cnt_d = '0;
    else if (cnt_q != '1)     cnt_d = cnt_q + 1'b1;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    grant_d     = '0;
    done_d      = '0;
    err_d       = 1'b0;
    err_id_d    = err_id_q;
    busy_d      = (state_d != ST_IDLE);
    a_d         = (state_d == ST_S1) || (state_d == ST_S3);
    det_rst_n_d = (state_d != ST_ERR);
    if (state_d == ST_S1 || state_d == ST_S2 || state_d == ST_S3 || state_d == ST_S4)
      grant_d = NREQ'(1) << id_d;
    if (state_d == ST_DONE)
      done_d = NREQ'(1) << id_d;
    if (state_d == ST_ERR) begin
      err_d    = 1'b1;
      err_id_d = id_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      id_q        <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      err_id_q    <= '0;
      busy_q      <= 1'b0;
      a_q         <= 1'b0;
      det_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_id_q    <= err_id_d;
      busy_q      <= busy_d;
      a_q         <= a_d;
      det_rst_n_q <= det_rst_n_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_id    = err_id_q;
  assign busy      = busy_q;
  assign A_out     = a_q;
  assign det_rst_n = det_rst_n_q;

endmodule

// File: tb/tb_toggle_seq_ctrl.sv
// Bench for toggle_seq_ctrl: directed reset checks, then randomized grants with a detector
// model and fault injection, checked by a scoreboard fed from a round-robin reference model.
module tb_toggle_seq_ctrl;
  localparam int NREQ = 4;
  localparam int HOLD = 3;
  localparam int TMO  = 15;
  localparam int IDW  = 2;
  localparam int NTXN = 40;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req, grant, done;
  logic            err, busy, A_out, det_rst_n, K1_in, K2_in;
  logic [IDW-1:0]  err_id;

  toggle_seq_ctrl #(.NREQ(NREQ), .HOLD(HOLD), .TMO(TMO), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .done(done), .err(err),
    .err_id(err_id), .busy(busy), .A_out(A_out), .det_rst_n(det_rst_n),
    .K1_in(K1_in), .K2_in(K2_in)
  );

  always #5 clk = ~clk;

  // Detector model: IDLE -A-> Start -!A-> Stop -A-> Clear -!A-> IDLE
  int dq = 0;
  bit sup_k1 = 0, sup_k2 = 0, frc_k1 = 0, frc_k2 = 0;
  always @(posedge clk) begin
    if (!det_rst_n) dq <= 0;
    else case (dq)
      0: if (A_out)  dq <= 1;
      1: if (!A_out) dq <= 2;
      2: if (A_out)  dq <= 3;
      default: if (!A_out) dq <= 0;
    endcase
  end
  assign K2_in = ((dq == 2) && A_out && !sup_k2) || frc_k2;
  assign K1_in = ((dq == 3) && !A_out && !sup_k1) || frc_k1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    int id;
    bit is_err;
    int lat;
    bit chk_a;
  } exp_t;
  exp_t sb[$];

  function automatic logic exp_a(input int k);
    return (k < HOLD) || (k == 2 * HOLD);
  endfunction

  // Monitor: decoupled from stimulus, compares every grant and outcome with the scoreboard.
  bit mon_en = 0;
  int cyc = 0, t0 = 0, n_out = 0;
  bit in_seq = 0;
  logic [NREQ-1:0] prev_grant = '0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (grant != 0 && prev_grant == 0) begin
        t0 = cyc;
        in_seq = 1;
        if (sb.size() == 0) chk("grant_expected", sb.size(), 1);
        else chk("grant_onehot", grant, 32'(1) << sb[0].id);
        chk("idle_before_grant", prev_busy, 0);
      end
      if (in_seq && sb.size() > 0 && sb[0].chk_a && (cyc - t0) <= 2 * HOLD + 1) begin
        chk("a_pattern", A_out, exp_a(cyc - t0));
        chk("busy_in_seq", busy, 1);
      end
      if (done != 0 || err) begin
        if (sb.size() == 0) chk("outcome_expected", sb.size(), 1);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("outcome_is_err", err, e.is_err);
          chk("outcome_latency", cyc - t0, e.lat);
          chk("outcome_busy", busy, 1);
          chk("outcome_grant_low", grant, 0);
          chk("outcome_a_low", A_out, 0);
          if (e.is_err) begin
            chk("err_id", err_id, e.id);
            chk("err_done_low", done, 0);
            chk("err_det_rst_n", det_rst_n, 0);
          end else begin
            chk("done_vec", done, 32'(1) << e.id);
          end
          $display("txn %0d: id=%0d %s lat=%0d", n_out, e.id, e.is_err ? "err" : "done", cyc - t0);
          n_out++;
        end
        in_seq = 0;
      end
    end
    prev_grant = grant;
    prev_busy  = busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int mptr;
    rst = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_id", err_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_a", A_out, 0);
    chk("rst_det_rst_n", det_rst_n, 0);

    // Release with req[3] held: detector leaves reset first, grant one cycle later.
    req = 4'b1000;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_det_rst_n", det_rst_n, 1);
    chk("rel_grant_wait", grant, 0);
    @(negedge clk);
    chk("rel_grant", grant, 4'b1000);
    repeat (4) @(negedge clk);
    chk("s2_a", A_out, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_grant", grant, 0);
    chk("midrst_a", A_out, 0);
    chk("midrst_det_rst_n", det_rst_n, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel2_grant_wait", grant, 0);
    @(negedge clk);
    chk("rel2_grant", grant, 4'b1000);
    repeat (7) @(negedge clk);
    chk("rel2_done_early", done, 0);
    @(negedge clk);
    chk("rel2_done", done, 4'b1000);
    chk("rel2_busy", busy, 1);
    req = '0;
    @(negedge clk);
    chk("rel2_idle", busy, 0);

    // Randomized phase; reference pointer follows grant 3 completing.
    mon_en = 1;
    mptr = 0;
    for (int n = 0; n < NTXN; n++) begin
      logic [NREQ-1:0] mask;
      int mode, c, g, lat;
      bit got;
      exp_t e;
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      mode = $urandom_range(0, 5);
      c    = $urandom_range(0, 2 * HOLD - 1);
      g    = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && mask[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
      case (mode)
        0: lat = 2 * HOLD + 2;        // clean sequence
        1: lat = 2 * HOLD + TMO;      // K2 never arrives
        2: lat = 2 * HOLD + 1 + TMO;  // K1 never arrives
        3, 4: lat = c + 1;            // spurious K1/K2 while driving
        default: lat = 2 * HOLD + 1;  // K1 while waiting for K2
      endcase
      e = '{id: g, is_err: (mode != 0), lat: lat, chk_a: (mode == 0)};
      sb.push_back(e);
      mptr = (g + 1) % NREQ;
      sup_k1 = (mode == 2);
      sup_k2 = (mode == 1);
      req = mask;

      got = 0;
      for (int w = 0; w < 4 && !got; w++) begin
        @(negedge clk);
        got = (grant != 0);
      end
      chk("grant_wait", got, 1);

      got = 0;
      for (int k = 0; k < 2 * HOLD + TMO + 6 && !got; k++) begin
        frc_k1 = (mode == 3 && k == c) || (mode == 5 && k == 2 * HOLD);
        frc_k2 = (mode == 4 && k == c);
        if (k == 2) req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
        @(negedge clk);
        got = (done != 0) || err;
      end
      chk("outcome_wait", got, 1);
      frc_k1 = 0;
      frc_k2 = 0;
      sup_k1 = 0;
      sup_k2 = 0;
      req = '0;
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("idle_at_end", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
